// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - parallel-to-serial operand feeder with one-entry holding register
module serial_operand_feeder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         a,
    output logic         b,
    output logic         bit_valid,
    output logic         carry_clear,
    output logic         last,
    output logic         busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sh_a;
    logic [W-1:0]  sh_b;
    logic [W-1:0]  hold_a;
    logic [W-1:0]  hold_b;
    logic          hold_full;

    logic accept;
    logic at_last;
    logic shifter_free;

    assign in_ready     = !hold_full && !clear;
    assign accept       = in_valid && in_ready;
    assign at_last      = (state == SHIFT) && (cnt == CNT_LAST);
    assign shifter_free = (state == IDLE) || at_last;

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            hold_a    <= '0;
            hold_b    <= '0;
            hold_full <= 1'b0;
        end else if (shifter_free) begin
            // A new frame starts right after the last bit, so frames abut with no gap.
            cnt <= '0;
            if (accept) begin
                sh_a  <= in_a;
                sh_b  <= in_b;
                state <= SHIFT;
            end else if (hold_full) begin
                sh_a      <= hold_a;
                sh_b      <= hold_b;
                hold_full <= 1'b0;
                state     <= SHIFT;
            end else begin
                sh_a  <= '0;
                sh_b  <= '0;
                state <= IDLE;
            end
        end else begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            cnt  <= cnt + CW'(1);
            if (accept) begin
                hold_a    <= in_a;
                hold_b    <= in_b;
                hold_full <= 1'b1;
            end
        end
    end

    assign a           = (state == SHIFT) && sh_a[0];
    assign b           = (state == SHIFT) && sh_b[0];
    assign bit_valid   = (state == SHIFT);
    assign carry_clear = (state == SHIFT) && (cnt == '0);
    assign last        = at_last;
    assign busy        = (state == SHIFT) || hold_full;
endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - scoreboard bench for W=8 and W=1 feeders
module tb_serial_operand_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear8 = 1'b1, in_valid8 = 1'b0;
    logic [7:0] in_a8 = '0, in_b8 = '0;
    logic       in_ready8, a8, b8, bv8, cc8, last8, busy8;

    logic       clear1 = 1'b1, in_valid1 = 1'b0;
    logic [0:0] in_a1 = '0, in_b1 = '0;
    logic       in_ready1, a1, b1, bv1, cc1, last1, busy1;

    serial_operand_feeder #(.W(8)) dut8 (
        .clk(clk), .clear(clear8), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(in_a8), .in_b(in_b8), .a(a8), .b(b8), .bit_valid(bv8),
        .carry_clear(cc8), .last(last8), .busy(busy8)
    );

    serial_operand_feeder #(.W(1)) dut1 (
        .clk(clk), .clear(clear1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .a(a1), .b(b1), .bit_valid(bv1),
        .carry_clear(cc1), .last(last1), .busy(busy1)
    );

    // One entry per accepted pair: the frame occupies cycles start .. start+w-1.
    typedef struct {
        int         u;
        logic [7:0] a;
        logic [7:0] b;
        int         start;
        int         w;
    } frame_t;

    frame_t fq[$];
    int     last_end[2];
    bit     armed[2];
    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int u, input int c, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s unit%0d cycle %0d: got %b expected %b", name, u, c, got, exp);
        end
    endtask

    task automatic mon(input int u);
        int c, w;
        logic clr, vld, rdy, ga, gb, gbv, gcc, glast, gbusy;
        logic ea, eb, ebv, ecc, elast, ebusy, epend, erdy;
        logic [7:0] ta, tb;
        frame_t f;
        c = cyc;
        w = (u == 0) ? 8 : 1;
        if (u == 0) begin
            clr = clear8; vld = in_valid8; rdy = in_ready8; ga = a8; gb = b8;
            gbv = bv8; gcc = cc8; glast = last8; gbusy = busy8;
        end else begin
            clr = clear1; vld = in_valid1; rdy = in_ready1; ga = a1; gb = b1;
            gbv = bv1; gcc = cc1; glast = last1; gbusy = busy1;
        end
        for (int i = fq.size() - 1; i >= 0; i--)
            if (fq[i].u == u && fq[i].start + fq[i].w <= c) fq.delete(i);
        ea = 0; eb = 0; ebv = 0; ecc = 0; elast = 0; ebusy = 0; epend = 0;
        for (int i = 0; i < fq.size(); i++) begin
            if (fq[i].u == u) begin
                ebusy = 1;
                if (fq[i].start > c) epend = 1;
                else begin
                    ta = fq[i].a;
                    tb = fq[i].b;
                    ea = ta[c - fq[i].start];
                    eb = tb[c - fq[i].start];
                    ebv = 1;
                    ecc = (c == fq[i].start);
                    elast = (c == fq[i].start + w - 1);
                end
            end
        end
        erdy = !clr && !epend;
        if (armed[u]) begin
            cmp("a", u, c, ga, ea);
            cmp("b", u, c, gb, eb);
            cmp("bit_valid", u, c, gbv, ebv);
            cmp("carry_clear", u, c, gcc, ecc);
            cmp("last", u, c, glast, elast);
            cmp("busy", u, c, gbusy, ebusy);
            cmp("in_ready", u, c, rdy, erdy);
        end
        if (clr) begin
            for (int i = fq.size() - 1; i >= 0; i--)
                if (fq[i].u == u) fq.delete(i);
            last_end[u] = 0;
            armed[u] = 1;
        end else if (vld && erdy) begin
            f.u = u;
            f.a = (u == 0) ? in_a8 : {7'd0, in_a1};
            f.b = (u == 0) ? in_b8 : {7'd0, in_b1};
            f.w = w;
            f.start = (c + 1 > last_end[u]) ? c + 1 : last_end[u];
            last_end[u] = f.start + w;
            fq.push_back(f);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic send8(input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        in_valid8 = 1; in_a8 = x; in_b8 = y;
        @(negedge clk);
        while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
        if (!in_ready8) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout unit0 cycle %0d: got in_ready 0 expected 1", cyc);
        end
        @(posedge clk); #1;
        in_valid8 = 0; in_a8 = 8'($urandom); in_b8 = 8'($urandom);
    endtask

    task automatic send1(input logic x, input logic y);
        int n = 0;
        in_valid1 = 1; in_a1 = x; in_b1 = y;
        @(negedge clk);
        while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
        if (!in_ready1) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout unit1 cycle %0d: got in_ready 0 expected 1", cyc);
        end
        @(posedge clk); #1;
        in_valid1 = 0; in_a1 = 1'($urandom); in_b1 = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr8(input int n);
        clear8 = 1; in_valid8 = 0;
        idle(n);
        clear8 = 0;
    endtask

    task automatic clr1(input int n);
        clear1 = 1; in_valid1 = 0;
        idle(n);
        clear1 = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        fork
            begin
                clr8(2);
                idle(2);
                send8(8'd3, 8'd7);
                idle(12);
                send8(8'd255, 8'd255);
                send8(8'd100, 8'd97);
                idle(20);
                send8(8'd1, 8'd2);
                send8(8'd3, 8'd4);
                send8(8'd5, 8'd6);
                idle(30);
                send8(8'd10, 8'd20);
                send8(8'd30, 8'd40);
                idle(2);
                clr8(1);
                send8(8'd9, 8'd200);
                idle(12);
                for (int i = 0; i < 120; i++) begin
                    if ($urandom_range(29) == 0) clr8(1 + $urandom_range(1));
                    send8(8'($urandom), 8'($urandom));
                    if ($urandom_range(2) == 0) idle($urandom_range(9));
                end
            end
            begin
                clr1(2);
                idle(2);
                send1(1'b1, 1'b0);
                send1(1'b0, 1'b1);
                send1(1'b1, 1'b1);
                idle(4);
                for (int i = 0; i < 100; i++) begin
                    if ($urandom_range(24) == 0) clr1(1);
                    send1(1'($urandom), 1'($urandom));
                    if ($urandom_range(3) == 0) idle($urandom_range(3));
                end
            end
        join
        idle(14);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_operand_feeder.md
# serial_operand_feeder

Parallel-to-serial front end for the serial adder. Accepts a pair of W-bit operands through a valid/ready handshake. Shifts both operands out LSB-first, one bit pair per clock, with framing strobes so the adder can clear its carry on bit 0. A one-entry holding register allows the next pair to be accepted mid-frame, so consecutive frames stream with zero idle cycles.

## Interface
- W, 8: operand width in bits; legal range W >= 1.

- clk  input  1  rising-edge clock.
- clear  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  feeder can accept a pair this cycle (combinational).
- in_a  input  W  operand A, parallel.
- in_b  input  W  operand B, parallel.
- a  output  1  serial bit of A, registered, to adder input a.
- b  output  1  serial bit of B, registered, to adder input b.
- bit_valid  output  1  a/b carry a real bit this cycle.
- carry_clear  output  1  bit 0 of a frame is on a/b; the adder forces carry-in to 0 this cycle.
- last  output  1  bit W-1 of a frame is on a/b.
- busy  output  1  a frame is shifting or the holding register is full.

## Operation
- Storage:
  - shifter: sh_a, sh_b (W bits each) plus bit counter cnt (0..W-1).
  - holder: hold_a, hold_b plus hold_full.
  - state: IDLE or SHIFT.
- Handshake:
  - in_ready = !hold_full && !clear.
  - A pair transfers on a rising edge where in_valid && in_ready.
  - in_a/in_b are don't-care when in_valid is low.
- Shifter free at an edge = state is IDLE, or state is SHIFT with cnt == W-1.
- Accept at an edge:
  - Shifter free: load the pair directly into sh_a/sh_b, set cnt=0, state=SHIFT.
  - Shifter not free: store the pair in the holder, set hold_full=1.
- Shifter free, hold_full=1, no accept: load sh_* from hold_*, set cnt=0, hold_full=0, state=SHIFT.
  - An accept cannot coincide with this, because in_ready is low.
- SHIFT, cnt < W-1: shift sh_a/sh_b right by 1 (zero fill), cnt++.
- SHIFT, cnt == W-1, nothing to load: state goes to IDLE.
- Outputs:
  - a = sh_a[0] and b = sh_b[0] while SHIFT; both are 0 in IDLE.
  - bit_valid = (state==SHIFT).
  - carry_clear = SHIFT && cnt==0.
  - last = SHIFT && cnt==W-1.
  - busy = SHIFT || hold_full.
- W=1: every frame is one cycle long; carry_clear and last are high in the same cycle.
- Operands are unsigned and consumed whole; no width extension or truncation.

## Timing
- Reset (clear high at an edge):
  - state=IDLE, cnt=0, hold_full=0, sh_*=0, hold_*=0.
  - a=b=bit_valid=carry_clear=last=busy=0.
  - in_ready=0 while clear is high.
- Clear mid-frame aborts the frame and discards the holder; no partial bits follow.
- Latency: a pair accepted at edge N while idle puts bit 0 on a/b in the cycle after N. bit_valid stays high for exactly W cycles.
- Throughput: one pair per W cycles sustained. If pair k+1 is accepted before frame k's last bit, carry_clear for k+1 immediately follows last for k, with no gap.
- Backpressure: with the shifter busy and the holder full, in_ready stays low until the edge where the holder drains into the shifter. It rises in the following cycle.
- The downstream adder samples a/b on the same edge that advances the feeder; the feeder has no stall input.

## Test plan
- Reset:
  - Stimulus: assert clear for 2 cycles.
  - Required: all outputs 0 and in_ready low during clear; in_ready=1 and busy=0 after clear drops.
- Single pair, W=8:
  - Stimulus: in_a=3, in_b=7 accepted at edge N.
  - Required:
    - Cycles N+1..N+8: a = 1,1,0,0,0,0,0,0 and b = 1,1,1,0,0,0,0,0.
    - carry_clear only at N+1 and last only at N+8.
    - bit_valid low at N+9.
- Back-to-back:
  - Stimulus: 255+255 accepted at edge N, then 100+97 presented from N+1 with in_valid held.
  - Required:
    - Second pair accepted at N+1 into the holder.
    - carry_clear at N+9 and a stream 0,0,1,0,0,1,1,0 over N+9..N+16.
    - bit_valid continuously high over N+1..N+16.
- Backpressure:
  - Stimulus: three pairs offered continuously.
  - Required:
    - Third pair: in_ready low from N+2 until the holder drains at edge N+8; third pair accepted at N+9.
    - No pair lost or duplicated.
- Clear mid-frame:
  - Stimulus: clear at frame cycle 4 with the holder full.
  - Required: outputs and busy 0 in the next cycle; a fresh pair then streams correctly from carry_clear.
- W=1 instance:
  - Stimulus: pairs (1,0), (0,1), (1,1) streamed.
  - Required: one bit per cycle; carry_clear=last=1 on every valid cycle.
